// File: rtl/fir_tap_loader.sv
// fir_tap_loader
//   Shadow coefficient RAM plus load controller for the configurable FIR's
//   tap programming port. Taps are written into the shadow RAM while idle.
//   A load_start pulse disables the FIR for two cycles, re-enables it, then
//   streams all T taps (k = 0..T-1) over a valid/ready handshake and waits
//   for the FIR's completion flag. A stall watchdog aborts the load.
//
// Ports
//   clk, reset             : clock, asynchronous active-high reset
//   coef_wr_addr/data/valid: shadow RAM write request
//   coef_wr_ready          : high in IDLE only (state decode)
//   load_start             : request to (re)program the FIR, IDLE only
//   busy / done / error    : load in progress / success pulse / sticky timeout
//   fir_enable             : FIR enable line
//   tap_dout/_valid/_ready : tap stream to the FIR
//   tap_dout_done          : FIR reports all taps received
module fir_tap_loader #(
  parameter int unsigned G_NUM_STAGES_LOG2  = 2,
  parameter int unsigned G_STAGE_DEPTH_LOG2 = 2,
  parameter int unsigned G_TAP_WIDTH        = 16,
  parameter int unsigned G_TIMEOUT          = 1024
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2-1:0] coef_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]                         coef_wr_data,
  input  logic                                           coef_wr_valid,
  output logic                                           coef_wr_ready,
  input  logic                                           load_start,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           error,
  output logic                                           fir_enable,
  output logic [G_TAP_WIDTH-1:0]                         tap_dout,
  output logic                                           tap_dout_valid,
  input  logic                                           tap_dout_ready,
  input  logic                                           tap_dout_done
);

  localparam int unsigned A  = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2;
  localparam int unsigned T  = 1 << A;
  localparam int unsigned TW = $clog2(G_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISABLE,
    S_STREAM,
    S_WAIT_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [A-1:0]           k_q, k_d;
  logic                   dis_q, dis_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   en_q, en_d;
  logic                   valid_q, valid_d;
  logic [G_TAP_WIDTH-1:0] dout_q, dout_d;
  logic                   timeout;

  logic [G_TAP_WIDTH-1:0] ram_q [T];

  assign coef_wr_ready  = (state_q == S_IDLE);
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign fir_enable     = en_q;
  assign tap_dout       = dout_q;
  assign tap_dout_valid = valid_q;

  // Shadow RAM: no reset, contents survive reset and aborted loads.
  always_ff @(posedge clk) begin
    if (coef_wr_valid && (state_q == S_IDLE)) begin
      ram_q[coef_wr_addr] <= coef_wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dis_d   = dis_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    en_d    = en_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    timeout = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_DISABLE;
          busy_d  = 1'b1;
          en_d    = 1'b0;
          error_d = 1'b0;
          k_d     = '0;
          dis_d   = 1'b0;
          tmo_d   = '0;
        end
      end

      S_DISABLE: begin
        en_d = 1'b0;
        if (!dis_q) begin
          dis_d = 1'b1;
        end else begin
          // Second disable cycle: read of tap 0 lands in the output register.
          state_d = S_STREAM;
          dis_d   = 1'b0;
          en_d    = 1'b1;
          valid_d = 1'b1;
          dout_d  = ram_q[k_q];
          tmo_d   = '0;
        end
      end

      S_STREAM: begin
        if (valid_q && tap_dout_ready) begin
          tmo_d = '0;
          if (k_q == A'(T - 1)) begin
            valid_d = 1'b0;
            state_d = S_WAIT_DONE;
          end else begin
            // Next tap is read straight into the output register on the
            // accepting edge, so back-to-back beats have no bubble.
            k_d    = k_q + A'(1);
            dout_d = ram_q[k_q + A'(1)];
          end
        end else begin
          timeout = (tmo_q == TW'(G_TIMEOUT - 1));
          tmo_d   = tmo_q + TW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (tap_dout_done) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timeout = (tmo_q == TW'(G_TIMEOUT - 1));
          tmo_d   = tmo_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      error_d = 1'b1;
      en_d    = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      tmo_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      dis_q   <= 1'b0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dis_q   <= dis_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Testbench for fir_tap_loader: randomized loads against a shadow-table
// model, a behavioural FIR tap port responder, and a scoreboard monitor.
module tb_fir_tap_loader;

  localparam int unsigned A   = 4;
  localparam int unsigned T   = 16;
  localparam int unsigned TMO = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [A-1:0]  coef_wr_addr;
  logic [15:0]   coef_wr_data;
  logic          coef_wr_valid;
  logic          coef_wr_ready;
  logic          load_start;
  logic          busy, done, error, fir_enable;
  logic [15:0]   tap_dout;
  logic          tap_dout_valid;
  logic          tap_dout_ready;
  logic          tap_dout_done;

  fir_tap_loader #(
    .G_NUM_STAGES_LOG2 (2),
    .G_STAGE_DEPTH_LOG2(2),
    .G_TAP_WIDTH       (16),
    .G_TIMEOUT         (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .coef_wr_addr  (coef_wr_addr),
    .coef_wr_data  (coef_wr_data),
    .coef_wr_valid (coef_wr_valid),
    .coef_wr_ready (coef_wr_ready),
    .load_start    (load_start),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .fir_enable    (fir_enable),
    .tap_dout      (tap_dout),
    .tap_dout_valid(tap_dout_valid),
    .tap_dout_ready(tap_dout_ready),
    .tap_dout_done (tap_dout_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] model_ram [T];
  logic [15:0] exp_q [$];
  int          done_cnt = 0;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;
  int          done_cyc = 0;
  bit          done_expected = 1'b0;
  int          ready_mode = 0;   // 0 always ready, 1 random, 2 stuck low
  logic [15:0] fir_h [T];
  int          fir_beats = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural FIR tap port: ready one cycle after enable, done pulse once
  // all T taps have been taken; received taps kept for the impulse check.
  bit r_acc, r_en;
  initial begin
    tap_dout_ready = 1'b0;
    tap_dout_done  = 1'b0;
    forever begin
      @(negedge clk);
      r_acc = tap_dout_valid && tap_dout_ready && !reset;
      r_en  = fir_enable;
      if (r_acc && fir_beats < T) fir_h[fir_beats] = tap_dout;
      @(posedge clk);
      #1;
      if (!r_en || reset) fir_beats = 0;
      else if (r_acc) fir_beats++;
      tap_dout_done = (fir_beats == T);
      if (fir_beats == T) fir_beats = 0;
      case (ready_mode)
        0:       tap_dout_ready = r_en;
        1:       tap_dout_ready = r_en && ($urandom_range(0, 3) != 0);
        default: tap_dout_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor.
  bit          m_stall = 1'b0;
  logic [15:0] m_pdata;
  logic [15:0] m_exp;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_stall = 1'b0;
      continue;
    end
    if (m_stall && tap_dout_valid) chk("hold_data", tap_dout, m_pdata);
    if (tap_dout_valid && tap_dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected actual=0x%0h required=no beat (cycle %0d)", tap_dout, cyc);
      end else begin
        m_exp = exp_q.pop_front();
        chk("tap_data", tap_dout, m_exp);
      end
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    m_stall = tap_dout_valid && !tap_dout_ready;
    m_pdata = tap_dout;
    if (done) begin
      chk("done_expected", done_expected, 1);
      chk("done_all_taps", exp_q.size(), 0);
      chk("busy_at_done", busy, 0);
      done_expected = 1'b0;
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d, input bit expect_acc);
    coef_wr_addr  = a[A-1:0];
    coef_wr_data  = d;
    coef_wr_valid = 1'b1;
    #1;
    chk("wr_ready", coef_wr_ready, expect_acc);
    if (expect_acc) model_ram[a] = d;
    tick();
    coef_wr_valid = 1'b0;
  endtask

  // Issues load_start (optionally with a same-cycle write), pushes the
  // expected tap sequence, checks the disable window; returns in t0+3.
  task automatic start_load(input int mode, input bit expect_done, input bit wr_en,
                            input int wa, input logic [15:0] wd, output int t0);
    ready_mode = mode;
    if (wr_en) begin
      coef_wr_addr  = wa[A-1:0];
      coef_wr_data  = wd;
      coef_wr_valid = 1'b1;
      model_ram[wa] = wd;
    end
    load_start = 1'b1;
    t0 = cyc;
    acc_cnt = 0;
    for (int k = 0; k < T; k++) exp_q.push_back(model_ram[k]);
    done_expected = expect_done;
    tick();
    load_start    = 1'b0;
    coef_wr_valid = 1'b0;
    @(negedge clk);
    chk("dis1_enable", fir_enable, 0);
    chk("dis1_busy", busy, 1);
    chk("dis1_error_clr", error, 0);
    @(negedge clk);
    chk("dis2_enable", fir_enable, 0);
    chk("dis2_valid", tap_dout_valid, 0);
    @(negedge clk);
    chk("str_enable", fir_enable, 1);
    chk("str_valid", tap_dout_valid, 1);
    chk("str_tap0", tap_dout, model_ram[0]);
  endtask

  task automatic wait_done(input int budget, input string name);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, done_cnt - start, 1);
  endtask

  task automatic check_idle_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_en"}, fir_enable, 0);
    chk({name, "_valid"}, tap_dout_valid, 0);
    chk({name, "_dout"}, tap_dout, 0);
    chk({name, "_wr_ready"}, coef_wr_ready, 1);
  endtask

  int t0;
  int saved;
  int n;
  logic [31:0] y;

  initial begin
    reset = 1'b1; load_start = 1'b0; coef_wr_valid = 1'b0;
    coef_wr_addr = '0; coef_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("rst_held");
    reset = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_rel");

    // Ramp table, ready always high: exact cycle timing.
    for (int k = 0; k < T; k++) wr(k, 16'h0100 + 16'(k), 1'b1);
    start_load(0, 1'b1, 1'b0, 0, 16'h0, t0);
    wait_done(100, "ramp_done");
    chk("ramp_beats", acc_cnt, T);
    chk("ramp_last_beat_cyc", last_acc_cyc, t0 + 3 + T);
    chk("ramp_done_cyc", done_cyc, t0 + 5 + T);
    @(negedge clk);
    chk("ramp_enable_end", fir_enable, 1);
    chk("ramp_busy_end", busy, 0);

    // Same table, random ready.
    tick();
    start_load(1, 1'b1, 1'b0, 0, 16'h0, t0);
    wait_done(300, "rnd_done");
    chk("rnd_beats", acc_cnt, T);

    // Random table; writes attempted mid-load must be refused.
    tick();
    for (int k = 0; k < T; k++) wr(k, 16'($urandom), 1'b1);
    start_load(0, 1'b1, 1'b0, 0, 16'h0, t0);
    wr(3, 16'hDEAD, 1'b0);
    wr(9, 16'hBEEF, 1'b0);
    wait_done(100, "busy_wr_done");
    tick();
    start_load(1, 1'b1, 1'b0, 0, 16'h0, t0);
    wait_done(300, "ram_kept_done");

    // Write tap 5 in the load_start cycle.
    tick();
    start_load(0, 1'b1, 1'b1, 5, 16'h7FFF, t0);
    wait_done(100, "samecyc_done");

    // Stall watchdog.
    tick();
    start_load(2, 1'b0, 1'b0, 0, 16'h0, t0);
    saved = done_cnt;
    repeat (31) @(negedge clk);
    chk("tmo_pre_error", error, 0);
    chk("tmo_pre_valid", tap_dout_valid, 1);
    @(negedge clk);
    chk("tmo_error", error, 1);
    chk("tmo_enable", fir_enable, 0);
    chk("tmo_valid", tap_dout_valid, 0);
    chk("tmo_busy", busy, 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("tmo_no_done", done_cnt, saved);
    chk("tmo_error_sticky", error, 1);
    tick();
    start_load(0, 1'b1, 1'b0, 0, 16'h0, t0);
    wait_done(100, "after_tmo_done");

    // Reset while presenting tap 7.
    tick();
    start_load(0, 1'b1, 1'b0, 0, 16'h0, t0);
    n = 0;
    while (acc_cnt < 7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_k7", acc_cnt, 7);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_zero("mid_rst");
    exp_q.delete();
    done_expected = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    start_load(1, 1'b1, 1'b0, 0, 16'h0, t0);
    wait_done(300, "post_rst_done");
    chk("post_rst_beats", acc_cnt, T);

    // Impulse taps; FIR impulse response must reproduce them.
    tick();
    wr(0, 16'h4000, 1'b1);
    for (int k = 1; k < T; k++) wr(k, 16'h0000, 1'b1);
    start_load(0, 1'b1, 1'b0, 0, 16'h0, t0);
    wait_done(100, "imp_done");
    for (int i = 0; i < T; i++) begin
      y = '0;
      for (int k = 0; k <= i; k++) y += 32'(fir_h[k]) * ((i - k == 0) ? 32'd1 : 32'd0);
      chk("impulse_y", y, 32'(model_ram[i]));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
